// File: rtl/integral_rect_reader.sv
// integral_rect_reader: reads the corners of a rectangle from the 20x20 integral buffer and returns D - B - C + A.
// Latency: n corner reads (n in 1,2,4) -> RES_VALID at t+n+3 after acceptance (+1 with RECT_WEIGHT_EN); range error -> t+1.
// Backpressure: one request in flight; REQ_READY only in IDLE with INT_DONE high; the result is held until RES_READY.
//
// Ports:
//   CLK, RESET         rising-edge clock, synchronous active-high reset
//   INT_DONE           integral buffer valid, sampled at request acceptance
//   REQ_*              rectangle request (X, Y, W, H) with valid/ready handshake
//   REQ_WEIGHT         signed 3-bit weight, present only with RECT_WEIGHT_EN
//   RD_EN/RD_ADDR      read port to the integral buffer; RD_DATA is returned one cycle after RD_EN
//   RES_*              result with valid/ready handshake; RES_SUM is signed, RES_ERR flags an out-of-range request
//
// Optional feature macro RECT_WEIGHT_EN: adds REQ_WEIGHT, widens RES_SUM to SUM_W+3 bits, and adds one multiply cycle.

module integral_rect_reader #(
  parameter int WIN_W  = 20,
  parameter int WIN_H  = 20,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int SUM_W  = 34
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    INT_DONE,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [4:0]              REQ_X,
  input  logic [4:0]              REQ_Y,
  input  logic [4:0]              REQ_W,
  input  logic [4:0]              REQ_H,
`ifdef RECT_WEIGHT_EN
  input  logic signed [2:0]       REQ_WEIGHT,
`endif
  output logic                    RD_EN,
  output logic [ADDR_W-1:0]       RD_ADDR,
  input  logic [DATA_W-1:0]       RD_DATA,
  output logic                    RES_VALID,
  input  logic                    RES_READY,
`ifdef RECT_WEIGHT_EN
  output logic signed [SUM_W+2:0] RES_SUM,
`else
  output logic signed [SUM_W-1:0] RES_SUM,
`endif
  output logic                    RES_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DRAIN,
    S_MUL,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [4:0] x_q, y_q, w_q, h_q;
  logic       err_q;

  // Corner sequencing: cur_q is the corner being read (0=D,1=B,2=C,3=A), rest_q the corners still to read
  logic [1:0] cur_q;
  logic [3:0] rest_q;
  logic [1:0] nxt_idx;

  // Read return tracking: data for a read lands one cycle after RD_EN
  logic       rd_pend_q;
  logic       rd_neg_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic signed [SUM_W-1:0] acc_q;
  logic signed [SUM_W-1:0] rd_ext;

  logic       accept;
  logic       req_err;
  logic [5:0] req_xe, req_ye;
  logic [5:0] x2, y2, xm1, ym1;
  logic [3:0] corner_mask;
  logic [ADDR_W-1:0] corner_addr [4];

`ifdef RECT_WEIGHT_EN
  logic signed [2:0]       wgt_q;
  logic signed [SUM_W+2:0] prod_q;
  logic signed [SUM_W+2:0] acc_x;
  logic signed [SUM_W+2:0] wgt_x;
`endif

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] col, input logic [5:0] row);
    cell_addr = ADDR_W'(32'(row) * WIN_W + 32'(col));
  endfunction

  // Lowest-numbered pending corner keeps the D, B, C, A order
  function automatic logic [1:0] first_set(input logic [3:0] m);
    first_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) first_set = 2'(i);
    end
  endfunction

  assign REQ_READY = (state_q == S_IDLE) && INT_DONE && !RESET;
  assign accept    = REQ_VALID && REQ_READY;

  // Range check on 6-bit sums so X+W cannot wrap
  always_comb begin
    req_xe  = {1'b0, REQ_X} + {1'b0, REQ_W};
    req_ye  = {1'b0, REQ_Y} + {1'b0, REQ_H};
    req_err = (REQ_W == 5'd0) || (REQ_H == 5'd0) ||
              (req_xe > 6'(WIN_W)) || (req_ye > 6'(WIN_H));
  end

  // Corner coordinates; X-1 / Y-1 wrap when X or Y is 0 but those corners are masked off
  always_comb begin
    x2  = {1'b0, x_q} + {1'b0, w_q} - 6'd1;
    y2  = {1'b0, y_q} + {1'b0, h_q} - 6'd1;
    xm1 = {1'b0, x_q} - 6'd1;
    ym1 = {1'b0, y_q} - 6'd1;
    corner_addr[0] = cell_addr(x2,  y2);
    corner_addr[1] = cell_addr(xm1, y2);
    corner_addr[2] = cell_addr(x2,  ym1);
    corner_addr[3] = cell_addr(xm1, ym1);
    corner_mask = {(x_q != 5'd0) && (y_q != 5'd0), (y_q != 5'd0), (x_q != 5'd0), 1'b1};
    nxt_idx = first_set(rest_q);
  end

  assign rd_ext = $signed({{(SUM_W-DATA_W){1'b0}}, RD_DATA});

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      // An erroring request presents its result directly from CHECK
      S_CHECK: begin
        if (err_q) state_d = RES_READY ? S_IDLE : S_OUT;
        else       state_d = S_ISSUE;
      end
      S_ISSUE: if (rest_q == 4'd0) state_d = S_DRAIN;
`ifdef RECT_WEIGHT_EN
      S_DRAIN: state_d = S_MUL;
      S_MUL:   state_d = S_OUT;
`else
      S_DRAIN: state_d = S_OUT;
`endif
      S_OUT:   if (RES_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      err_q     <= 1'b0;
      cur_q     <= '0;
      rest_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_neg_q  <= 1'b0;
      rd_addr_q <= '0;
      acc_q     <= '0;
`ifdef RECT_WEIGHT_EN
      wgt_q     <= '0;
      prod_q    <= '0;
`endif
    end else begin
      if (accept) begin
        x_q   <= REQ_X;
        y_q   <= REQ_Y;
        w_q   <= REQ_W;
        h_q   <= REQ_H;
        err_q <= req_err;
        acc_q <= '0;
`ifdef RECT_WEIGHT_EN
        wgt_q  <= REQ_WEIGHT;
        prod_q <= '0;
`endif
      end

      // D is always read first; queue the remaining valid corners
      if (state_q == S_CHECK && !err_q) begin
        rd_addr_q <= corner_addr[0];
        cur_q     <= 2'd0;
        rest_q    <= corner_mask & 4'b1110;
      end

      if (state_q == S_ISSUE && rest_q != 4'd0) begin
        rd_addr_q <= corner_addr[nxt_idx];
        cur_q     <= nxt_idx;
        rest_q    <= rest_q & ~(4'b0001 << nxt_idx);
      end

      // B and C are subtracted, D and A added
      rd_pend_q <= (state_q == S_ISSUE);
      rd_neg_q  <= (cur_q == 2'd1) || (cur_q == 2'd2);

      if (rd_pend_q) begin
        if (rd_neg_q) acc_q <= acc_q - rd_ext;
        else          acc_q <= acc_q + rd_ext;
      end

`ifdef RECT_WEIGHT_EN
      if (state_q == S_MUL) prod_q <= acc_x * wgt_x;
`endif
    end
  end

`ifdef RECT_WEIGHT_EN
  assign acc_x   = {{3{acc_q[SUM_W-1]}}, acc_q};
  assign wgt_x   = {{SUM_W{wgt_q[2]}}, wgt_q};
  assign RES_SUM = prod_q;
`else
  assign RES_SUM = acc_q;
`endif

  assign RD_EN     = (state_q == S_ISSUE);
  assign RD_ADDR   = rd_addr_q;
  assign RES_VALID = (state_q == S_OUT) || ((state_q == S_CHECK) && err_q);
  assign RES_ERR   = err_q;

endmodule

// File: tb/tb_integral_rect_reader.sv
// tb_integral_rect_reader: randomized and directed stimulus against a pixel-level reference model.
// Latency: n/a (bench).
// Backpressure: exercises RES_READY held low and immediate-ready result handshakes.

module tb_integral_rect_reader;

  localparam int WW = 20;
  localparam int WH = 20;
`ifdef RECT_WEIGHT_EN
  localparam int RW    = 37;
  localparam int EXTRA = 1;
`else
  localparam int RW    = 34;
  localparam int EXTRA = 0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              INT_DONE;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [4:0]        REQ_X, REQ_Y, REQ_W, REQ_H;
`ifdef RECT_WEIGHT_EN
  logic signed [2:0] REQ_WEIGHT;
`endif
  logic              RD_EN;
  logic [8:0]        RD_ADDR;
  logic [31:0]       RD_DATA;
  logic              RES_VALID;
  logic              RES_READY;
  logic signed [RW-1:0] RES_SUM;
  logic              RES_ERR;

  integral_rect_reader dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .INT_DONE  (INT_DONE),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_X     (REQ_X),
    .REQ_Y     (REQ_Y),
    .REQ_W     (REQ_W),
    .REQ_H     (REQ_H),
`ifdef RECT_WEIGHT_EN
    .REQ_WEIGHT(REQ_WEIGHT),
`endif
    .RD_EN     (RD_EN),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_SUM   (RES_SUM),
    .RES_ERR   (RES_ERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int unsigned pix   [WW*WH];
  int unsigned integ [WW*WH];

  logic [8:0] rd_q[$];
  int         rd_c_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Integral buffer: synchronous read, data one cycle after RD_EN
  always @(posedge CLK) begin
    if (RD_EN && RD_ADDR < 9'd400) RD_DATA <= integ[RD_ADDR];
  end

  always @(negedge CLK) begin
    if (RD_EN) begin
      rd_q.push_back(RD_ADDR);
      rd_c_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_integral();
    for (int y = 0; y < WH; y++) begin
      for (int x = 0; x < WW; x++) begin
        int unsigned v;
        v = pix[y*WW+x];
        if (x > 0) v += integ[y*WW+x-1];
        if (y > 0) v += integ[(y-1)*WW+x];
        if (x > 0 && y > 0) v -= integ[(y-1)*WW+x-1];
        integ[y*WW+x] = v;
      end
    end
  endtask

  // Reference: direct pixel summation over the rectangle
  function automatic longint rect_sum(input int x, input int y, input int w, input int h);
    longint s = 0;
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++)
        s += longint'(pix[r*WW+c]);
    return s;
  endfunction

  task automatic do_req(input int x, input int y, input int w, input int h, input int wt, input bit hold);
    int     t_acc, t_res, n, lat;
    bit     err, got;
    longint es;
    int     exp_addr[$];
    err = (w == 0) || (h == 0) || (x + w > WW) || (y + h > WH);
    es  = 0;
    t_acc = 0;
    t_res = 0;
    if (!err) begin
      int x2, y2;
      x2 = x + w - 1;
      y2 = y + h - 1;
      exp_addr.push_back(y2*WW + x2);
      if (x > 0) exp_addr.push_back(y2*WW + x - 1);
      if (y > 0) exp_addr.push_back((y-1)*WW + x2);
      if (x > 0 && y > 0) exp_addr.push_back((y-1)*WW + x - 1);
      es = rect_sum(x, y, w, h);
`ifdef RECT_WEIGHT_EN
      es = es * wt;
`endif
    end
    n   = exp_addr.size();
    lat = err ? 1 : n + 3 + EXTRA;

    @(posedge CLK) #1;
    rd_q.delete();
    rd_c_q.delete();
    REQ_X     = 5'(x);
    REQ_Y     = 5'(y);
    REQ_W     = 5'(w);
    REQ_H     = 5'(h);
`ifdef RECT_WEIGHT_EN
    REQ_WEIGHT = 3'(wt);
`endif
    REQ_VALID = 1'b1;
    RES_READY = !hold;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin got = 1; t_acc = cyc; end
    end
    chk("accept", longint'(got), 1);
    @(posedge CLK) #1;
    REQ_VALID = 1'b0;
    if (!got) return;

    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (RES_VALID) begin got = 1; t_res = cyc; end
    end
    chk("res_valid_seen", longint'(got), 1);
    if (!got) return;
    chk("latency", longint'(t_res - t_acc), longint'(lat));
    chk("res_sum", longint'(RES_SUM), es);
    chk("res_err", longint'(RES_ERR), longint'(err));
    chk("rd_count", longint'(rd_q.size()), longint'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++) begin
      chk("rd_addr", longint'(rd_q[i]), longint'(exp_addr[i]));
      chk("rd_cycle", longint'(rd_c_q[i] - t_acc), longint'(2 + i));
    end

    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge CLK);
        chk("hold_valid", longint'(RES_VALID), 1);
        chk("hold_sum", longint'(RES_SUM), es);
        chk("hold_err", longint'(RES_ERR), longint'(err));
        chk("hold_req_ready", longint'(REQ_READY), 0);
      end
      @(posedge CLK) #1;
      RES_READY = 1'b1;
      @(negedge CLK);
      chk("hold_valid_pulse", longint'(RES_VALID), 1);
      @(posedge CLK) #1;
      RES_READY = 1'b0;
    end else begin
      @(posedge CLK) #1;
    end
    @(negedge CLK);
    chk("idle_req_ready", longint'(REQ_READY), 1);
    chk("idle_res_valid", longint'(RES_VALID), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit saw_valid;
    RESET     = 1'b1;
    INT_DONE  = 1'b1;
    REQ_VALID = 1'b0;
    RES_READY = 1'b0;
    REQ_X = '0; REQ_Y = '0; REQ_W = '0; REQ_H = '0;
`ifdef RECT_WEIGHT_EN
    REQ_WEIGHT = 3'sd1;
`endif
    for (int i = 0; i < WW*WH; i++) pix[i] = 1;
    build_integral();

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", longint'(REQ_READY), 0);
    chk("rst_rd_en", longint'(RD_EN), 0);
    chk("rst_rd_addr", longint'(RD_ADDR), 0);
    chk("rst_res_valid", longint'(RES_VALID), 0);
    chk("rst_res_sum", longint'(RES_SUM), 0);
    chk("rst_res_err", longint'(RES_ERR), 0);
    @(posedge CLK) #1;
    RESET = 1'b0;

    // Directed cases on the all-ones image
    do_req(2, 3, 4, 5, 1, 0);
    do_req(0, 0, 20, 20, 1, 0);
    do_req(0, 5, 3, 2, 1, 0);
    do_req(18, 0, 3, 1, 1, 0);
    do_req(4, 4, 0, 3, 1, 0);
    do_req(19, 19, 1, 1, 1, 0);
    do_req(1, 1, 5, 5, 1, 1);
    do_req(10, 2, 11, 2, 1, 1);

    // No acceptance while the integral buffer is not valid
    @(posedge CLK) #1;
    rd_q.delete();
    INT_DONE  = 1'b0;
    REQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("no_ready_wo_int_done", longint'(REQ_READY), 0);
    end
    chk("no_reads_wo_int_done", longint'(rd_q.size()), 0);
    @(posedge CLK) #1;
    REQ_VALID = 1'b0;
    INT_DONE  = 1'b1;

    // Reset while reads are being issued
    @(posedge CLK) #1;
    rd_q.delete();
    REQ_X = 5'd2; REQ_Y = 5'd3; REQ_W = 5'd4; REQ_H = 5'd5;
    REQ_VALID = 1'b1;
    RES_READY = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (REQ_READY) got = 1;
    end
    chk("rst_mid_accept", longint'(got), 1);
    @(posedge CLK) #1;
    REQ_VALID = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      if (rd_q.size() > 0) got = 1;
    end
    chk("rst_mid_issue_seen", longint'(got), 1);
    RESET = 1'b1;
    @(posedge CLK) #1;
    @(negedge CLK);
    chk("rst_mid_req_ready", longint'(REQ_READY), 0);
    chk("rst_mid_rd_en", longint'(RD_EN), 0);
    chk("rst_mid_rd_addr", longint'(RD_ADDR), 0);
    chk("rst_mid_res_valid", longint'(RES_VALID), 0);
    chk("rst_mid_res_sum", longint'(RES_SUM), 0);
    chk("rst_mid_res_err", longint'(RES_ERR), 0);
    @(posedge CLK) #1;
    RESET = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (RES_VALID) saw_valid = 1;
    end
    chk("rst_mid_no_result", longint'(saw_valid), 0);
    do_req(2, 3, 4, 5, 1, 0);

`ifdef RECT_WEIGHT_EN
    do_req(2, 3, 4, 5, -2, 0);
    do_req(0, 0, 20, 20, -4, 1);
    do_req(5, 5, 3, 3, 3, 0);
`endif

    // Random image and random requests
    for (int i = 0; i < WW*WH; i++) pix[i] = $urandom_range(0, 1000);
    build_integral();
    for (int k = 0; k < 40; k++) begin
      int x, y, w, h, wt;
      bit hold;
      x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 19));
      y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 19));
      if ($urandom_range(0, 5) == 0 || x >= WW) w = int'($urandom_range(0, 31));
      else                                      w = int'($urandom_range(1, WW - x));
      if ($urandom_range(0, 5) == 0 || y >= WH) h = int'($urandom_range(0, 31));
      else                                      h = int'($urandom_range(1, WH - y));
      wt   = int'($urandom_range(0, 7)) - 4;
      hold = ($urandom_range(0, 3) == 0);
      do_req(x, y, w, h, wt, hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
